ssd_scan_decoder: RTL

SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

---
 rtl/ssd_scan_decoder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ssd_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed, active-low 7-segment display
// by watching the scan bus and capturing each digit once it has been stable long enough.
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  D_ssd,
    input  logic [3:0]  ssd_ctl,
    output logic [15:0] value,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_valid,
    output logic        err,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // cnt holds the number of identical samples seen so far; the edge that would
    // bring it to STABLE_CYCLES is the capture edge.
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  idx_lat;
    logic [7:0]  d_lat;
    logic [3:0]  seen;

    logic        sel;
    logic [1:0]  sel_idx;
    logic        same;
    logic        seg_legal;
    logic [3:0]  seg_nibble;
    logic [3:0]  idx_bit;

    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = {1'b1, 4'h0};
        case (seg)
            7'b0000001: r[3:0] = 4'h0;
            7'b1001111: r[3:0] = 4'h1;
            7'b0010010: r[3:0] = 4'h2;
            7'b0000110: r[3:0] = 4'h3;
            7'b1001100: r[3:0] = 4'h4;
            7'b0100100: r[3:0] = 4'h5;
            7'b0100000: r[3:0] = 4'h6;
            7'b0001111: r[3:0] = 4'h7;
            7'b0000000: r[3:0] = 4'h8;
            7'b0000100: r[3:0] = 4'h9;
            7'b0001000: r[3:0] = 4'hA;
            7'b1100000: r[3:0] = 4'hB;
            7'b0110001: r[3:0] = 4'hC;
            7'b1000010: r[3:0] = 4'hD;
            7'b0110000: r[3:0] = 4'hE;
            7'b0111000: r[3:0] = 4'hF;
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] ctl_select(input logic [3:0] ctl);
        logic [2:0] r;
        case (ctl)
            4'b1110: r = {1'b1, 2'd0};
            4'b1101: r = {1'b1, 2'd1};
            4'b1011: r = {1'b1, 2'd2};
            4'b0111: r = {1'b1, 2'd3};
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    always_comb begin
        {sel, sel_idx}          = ctl_select(ssd_ctl);
        same                    = (sel_idx == idx_lat) && (D_ssd == d_lat);
        {seg_legal, seg_nibble} = seg_decode(D_ssd[7:1]);
        idx_bit                 = 4'b0001 << idx_lat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            idx_lat     <= 2'd0;
            d_lat       <= 8'd0;
            seen        <= 4'd0;
            value       <= 16'd0;
            dp_out      <= 4'd0;
            digit_valid <= 4'd0;
            err         <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            err        <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel) begin
                        idx_lat <= sel_idx;
                        d_lat   <= D_ssd;
                        cnt     <= 4'd1;
                        state   <= TRACK;
                    end
                end
                TRACK, HOLD: begin
                    if (!sel) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else if (!same) begin
                        idx_lat <= sel_idx;
                        d_lat   <= D_ssd;
                        cnt     <= 4'd1;
                        state   <= TRACK;
                    end else if (state == TRACK) begin
                        cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
                        if (cnt >= CNT_LAST) begin
                            state <= HOLD;
                            if (seg_legal) begin
                                value[{idx_lat, 2'b00} +: 4] <= seg_nibble;
                                dp_out[idx_lat]              <= ~D_ssd[0];
                                digit_valid[idx_lat]         <= 1'b1;
                                // A completed frame restarts collection on the same edge.
                                if ((seen | idx_bit) == 4'hF) begin
                                    frame_done <= 1'b1;
                                    seen       <= 4'd0;
                                end else begin
                                    seen <= seen | idx_bit;
                                end
                            end else begin
                                digit_valid[idx_lat] <= 1'b0;
                                err                  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    cnt   <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
